// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if: CPU request bus plus SRAM port of the memory responder
interface cpu_mem_responder_if #(
  parameter int ADDR_W = 14
);
  logic req_i;
  logic read_i;
  logic write_i;
  logic [3:0] web_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [2:0] type_i;
  logic wait_o;
  logic [31:0] data_o;
  logic err_o;
  logic sram_ceb_o;
  logic [3:0] sram_web_o;
  logic [ADDR_W-1:0] sram_a_o;
  logic [31:0] sram_di_o;
  logic [31:0] sram_do_i;
  modport master (
    output req_i, read_i, write_i, web_i, addr_i, data_i, type_i, sram_do_i,
    input wait_o, data_o, err_o, sram_ceb_o, sram_web_o, sram_a_o, sram_di_o
  );
  modport slave (
    input req_i, read_i, write_i, web_i, addr_i, data_i, type_i, sram_do_i,
    output wait_o, data_o, err_o, sram_ceb_o, sram_web_o, sram_a_o, sram_di_o
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: CPU load/store to SRAM responder; define CPU_RSP_ERR_CHECK_EN to enable access-error checking
module cpu_mem_responder #(
  parameter int LATENCY = 2,
  parameter int ADDR_W = 14
) (
  input logic clk,
  input logic rst,
  cpu_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] sh;
  logic [31:0] ext;
  logic [2:0] type_q;
  logic wr_q;
  logic err_q;
  logic acc;
  logic err_in;
  assign acc = state == IDLE && bus.req_i && (bus.read_i || bus.write_i);
  assign bus.wait_o = acc || state == BUSY;
  assign bus.sram_a_o = addr_q[ADDR_W+1:2];
  assign bus.sram_di_o = data_q;
  assign sh = bus.sram_do_i >> {addr_q[1:0], 3'b000};
  // align the addressed lane down to bit 0, then extend per load type (unlisted codes load the whole word)
  always_comb
    ext = type_q == 3'b000 ? {{24{sh[7]}}, sh[7:0]} :
          type_q == 3'b001 ? {{16{sh[15]}}, sh[15:0]} :
          type_q == 3'b100 ? {24'd0, sh[7:0]} :
          type_q == 3'b101 ? {16'd0, sh[15:0]} : sh;
`ifdef CPU_RSP_ERR_CHECK_EN
  logic half;
  logic word;
  assign half = bus.type_i == 3'b001 || bus.type_i == 3'b101;
  assign word = !half && bus.type_i != 3'b000 && bus.type_i != 3'b100;
  assign err_in = |(bus.addr_i >> (ADDR_W + 2)) || (half && bus.addr_i[0]) || (word && |bus.addr_i[1:0]);
  // one-cycle error pulse lands in DONE of a flagged access
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.err_o <= 1'b0;
    else bus.err_o <= state == BUSY && cnt == 4'd0 && err_q;
`else
  assign err_in = 1'b0;
  assign bus.err_o = 1'b0;
`endif
  // request FSM: latch in IDLE, strobe SRAM on the first BUSY cycle, capture on the last, settle in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= '0;
      data_q <= 32'd0;
      type_q <= 3'd0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      bus.data_o <= 32'd0;
      bus.sram_ceb_o <= 1'b1;
      bus.sram_web_o <= 4'hF;
    end else begin
      bus.sram_ceb_o <= 1'b1;
      bus.sram_web_o <= 4'hF;
      case (state)
        IDLE: if (acc) begin
          state <= BUSY;
          cnt <= 4'(LATENCY - 1);
          addr_q <= bus.addr_i[ADDR_W+1:0];
          data_q <= bus.data_i;
          type_q <= bus.type_i;
          wr_q <= bus.write_i;
          err_q <= err_in;
          bus.sram_ceb_o <= err_in;
          bus.sram_web_o <= bus.write_i && !err_in ? bus.web_i : 4'hF;
        end
        BUSY: if (cnt == 4'd0) begin
          state <= DONE;
          if (!wr_q) bus.data_o <= err_q ? 32'd0 : ext;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: randomized self-checking bench with an SRAM model and a word-level reference memory
module tb_cpu_mem_responder;
  localparam int LATENCY = 2;
  localparam int ADDR_W = 14;
  localparam int DEPTH = 1 << ADDR_W;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int passed = 0;
  bit [31:0] sram [DEPTH];
  bit [31:0] ref_mem [DEPTH];
  logic [31:0] exp_data = 32'd0;
  bit [2:0] tys [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
  cpu_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();
  cpu_mem_responder #(.LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] lane_mask(logic [3:0] web);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i+:8] = web[i] ? 8'h00 : 8'hFF;
    return m;
  endfunction
  assign bus.sram_do_i = sram[bus.sram_a_o];
  always @(posedge clk)
    if (bus.sram_ceb_o === 1'b0)
      sram[bus.sram_a_o] <= (sram[bus.sram_a_o] & ~lane_mask(bus.sram_web_o)) | (bus.sram_di_o & lane_mask(bus.sram_web_o));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic bit exp_err(logic [31:0] a, logic [2:0] ty);
`ifdef CPU_RSP_ERR_CHECK_EN
    if ((a >> (ADDR_W + 2)) != 0) return 1'b1;
    case (ty)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return a[0];
      default: return a[1:0] != 2'd0;
    endcase
`else
    return 1'b0;
`endif
  endfunction
  function automatic logic [31:0] load(bit [31:0] w, logic [31:0] a, logic [2:0] ty);
    logic [31:0] s;
    s = w >> (8 * a[1:0]);
    case (ty)
      3'd0: return 32'($signed(s[7:0]));
      3'd1: return 32'($signed(s[15:0]));
      3'd4: return {24'd0, s[7:0]};
      3'd5: return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction
  task automatic access(input bit rd, input bit wr, input logic [2:0] ty, input logic [31:0] a, input logic [31:0] d, input logic [3:0] wb, input bit hold);
    int waits;
    int cebs;
    bit err;
    int idx;
    err = exp_err(a, ty);
    idx = int'((a >> 2) % DEPTH);
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.read_i = rd;
    bus.write_i = wr;
    bus.type_i = ty;
    bus.addr_i = a;
    bus.data_i = d;
    bus.web_i = wb;
    #1;
    chk("wait_accept", bus.wait_o, 1'b1);
    chk("ceb_accept", bus.sram_ceb_o, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) bus.req_i = 1'b0;
    waits = 1;
    cebs = 0;
    @(negedge clk);
    while (bus.wait_o && waits < 40) begin
      waits++;
      if (bus.sram_ceb_o === 1'b0) begin
        cebs++;
        chk("sram_a", bus.sram_a_o, idx);
        chk("sram_web", bus.sram_web_o, wr ? wb : 4'hF);
        if (wr) chk("sram_di", bus.sram_di_o, d);
      end
      @(negedge clk);
    end
    if (wr && !err) ref_mem[idx] = (ref_mem[idx] & ~lane_mask(wb)) | (d & lane_mask(wb));
    if (!wr) exp_data = err ? 32'd0 : load(ref_mem[idx], a, ty);
    chk("wait_cycles", waits, LATENCY + 1);
    chk("ceb_pulses", cebs, err ? 0 : 1);
    chk("err_done", bus.err_o, err);
    chk("ceb_done", bus.sram_ceb_o, 1'b1);
    chk("data_done", bus.data_o, exp_data);
  endtask
  initial begin
    rst = 1'b1;
    bus.req_i = 1'b0;
    bus.read_i = 1'b0;
    bus.write_i = 1'b0;
    bus.type_i = 3'd0;
    bus.addr_i = 32'd0;
    bus.data_i = 32'd0;
    bus.web_i = 4'hF;
    for (int i = 0; i < 64; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wait", bus.wait_o, 1'b0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_ceb", bus.sram_ceb_o, 1'b1);
    chk("rst_web", bus.sram_web_o, 4'hF);
    chk("rst_a", bus.sram_a_o, 0);
    chk("rst_di", bus.sram_di_o, 32'd0);
    sram[4] = 32'h8899AABB;
    ref_mem[4] = 32'h8899AABB;
    access(1, 0, 3'd2, 32'h10, 32'd0, 4'hF, 0);
    chk("lw_0x10", bus.data_o, 32'h8899AABB);
    sram[4] = 32'h80FF0000;
    ref_mem[4] = 32'h80FF0000;
    access(1, 0, 3'd0, 32'h13, 32'd0, 4'hF, 0);
    chk("lb_0x13", bus.data_o, 32'hFFFFFF80);
    access(1, 0, 3'd4, 32'h13, 32'd0, 4'hF, 0);
    chk("lbu_0x13", bus.data_o, 32'h00000080);
    access(1, 0, 3'd1, 32'h12, 32'd0, 4'hF, 0);
    chk("lh_0x12", bus.data_o, 32'hFFFF80FF);
    access(0, 1, 3'd2, 32'h20, 32'h0000BEEF, 4'b1100, 0);
    chk("sw_keeps_data", bus.data_o, 32'hFFFF80FF);
    access(1, 1, 3'd2, 32'h40, 32'h12345678, 4'b0000, 1);
    access(1, 0, 3'd2, 32'h40, 32'd0, 4'hF, 0);
    chk("rdwr_is_write", bus.data_o, 32'h12345678);
    @(negedge clk);
    bus.req_i = 1'b1;
    bus.read_i = 1'b1;
    bus.write_i = 1'b0;
    bus.type_i = 3'd2;
    bus.addr_i = 32'h10;
    @(posedge clk);
    #1;
    bus.req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_wait", bus.wait_o, 1'b0);
    chk("midrst_ceb", bus.sram_ceb_o, 1'b1);
    chk("midrst_data", bus.data_o, 32'd0);
    exp_data = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    access(1, 0, 3'd2, 32'h10, 32'd0, 4'hF, 0);
    access(1, 0, 3'd2, 32'h00010002, 32'd0, 4'hF, 0);
    for (int n = 0; n < 150; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 9) == 0) a = a | 32'h00010000;
      access(op != 1, op != 0, tys[$urandom_range(0, 5)], a, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
    end
    bus.req_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, SRAM cycles from access issue to read-data capture (legal 1..15).
REQ-002 SHALL have parameter ADDR_W, default 14, SRAM word-address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_i  input  1  CPU request strobe.
REQ-006 SHALL have port read_i  input  1  read request qualifier.
REQ-007 SHALL have port write_i  input  1  write request qualifier.
REQ-008 SHALL have port web_i  input  4  active-low byte write enables, already lane-aligned by the CPU.
REQ-009 SHALL have port addr_i  input  32  byte address.
REQ-010 SHALL have port data_i  input  32  lane-aligned store data.
REQ-011 SHALL have port type_i  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 SHALL have port wait_o  output  1  CPU stall request.
REQ-013 SHALL have port data_o  output  32  extended load data.
REQ-014 SHALL have port err_o  output  1  one-cycle access-error pulse.
REQ-015 SHALL have port sram_ceb_o  output  1  SRAM chip enable, active-low.
REQ-016 SHALL have port sram_web_o  output  4  SRAM byte write enables, active-low.
REQ-017 SHALL have port sram_a_o  output  ADDR_W  SRAM word address, equal to addr[ADDR_W+1:2].
REQ-018 SHALL have port sram_di_o  output  32  SRAM write data.
REQ-019 SHALL have port sram_do_i  input  32  SRAM read data.

Function
REQ-020 SHALL implement FSM IDLE, BUSY, DONE.
REQ-021 In IDLE, req_i&(read_i|write_i) SHALL register addr, data, web, type and op, SHALL go to BUSY, and wait_o SHALL be 1 combinationally in that same cycle.
REQ-022 When read_i and write_i are both high, the request SHALL be treated as a write.
REQ-023 In IDLE, when req_i is low or both qualifiers are low, wait_o SHALL be 0 and the state SHALL be held.
REQ-024 BUSY SHALL last exactly LATENCY cycles, counted by a 4-bit down-counter loaded with LATENCY-1.
REQ-025 BUSY SHALL hold wait_o=1.
REQ-026 sram_ceb_o SHALL be 0 only in the first BUSY cycle.
REQ-027 In the first BUSY cycle, sram_web_o SHALL be the registered web for writes and 4'hF for reads.
REQ-028 On the last BUSY cycle of a read, sram_do_i SHALL be captured.
REQ-029 DONE SHALL last one cycle with wait_o=0, then the FSM SHALL go to IDLE; req_i seen in DONE SHALL be ignored.
REQ-030 Total wait_o-high cycles per access SHALL be LATENCY+1.
REQ-031 Each read SHALL update data_o from DONE onward: captured word shifted right by 8*addr[1:0], then sign- or zero-extended per type (byte or half) or passed whole (LW).
REQ-032 data_o SHALL hold its value until the next read completes; writes SHALL leave data_o unchanged.
REQ-033 An unlisted type_i code SHALL be treated as LW.
REQ-034 Outside the first BUSY cycle, sram_ceb_o=1 and sram_web_o=4'hF; sram_a_o and sram_di_o SHALL be driven from the registered request.

Reset
REQ-035 Asserting rst at any time, including mid-BUSY, SHALL force IDLE and abandon the access.
REQ-036 Reset values SHALL be: wait_o=0, data_o=0, err_o=0, sram_ceb_o=1, sram_web_o=4'hF, counter=0, and all request registers 0.

Configuration
REQ-037 Macro CPU_RSP_ERR_CHECK_EN SHALL control access-error checking.
REQ-038 When the macro is defined, an access SHALL be flagged as an error if addr[31:ADDR_W+2] is nonzero, or if LW/SW has addr[1:0]≠0, or if LH/LHU has addr[0]=1.
REQ-039 A flagged access SHALL still wait LATENCY+1 cycles, SHALL keep sram_ceb_o=1 throughout, and SHALL pulse err_o=1 in DONE.
REQ-040 A flagged read SHALL set data_o=0.
REQ-041 When the macro is undefined, err_o SHALL be tied 0, upper address bits and alignment SHALL be ignored, and no checking logic SHALL be synthesized.

Verification
REQ-042 LATENCY=2: LW at 0x10 with sram_do_i=0x8899AABB → wait_o high 3 cycles, sram_a_o=4, one ceb pulse, data_o=0x8899AABB in DONE.
REQ-043 LB at 0x13 on word 0x80FF0000 → data_o=0xFFFFFF80; LBU at 0x13 → data_o=0x00000080; LH at 0x12 → data_o=0xFFFF80FF.
REQ-044 SW at 0x20, web_i=4'b1100, data_i=0x0000BEEF → one cycle with sram_ceb_o=0, sram_web_o=4'b1100, sram_di_o=0x0000BEEF; data_o unchanged.
REQ-045 req_i held high across DONE → second access starts only in the following IDLE cycle; read_i=write_i=1 → write performed.
REQ-046 rst pulsed in the second BUSY cycle → wait_o=0, sram_ceb_o=1, data_o=0 immediately; the next request completes normally.
REQ-047 With CPU_RSP_ERR_CHECK_EN, LW at 0x00010002 → no ceb pulse, err_o=1 for one cycle, data_o=0; without the macro → normal access to word 0x0000, err_o=0.
